// File: rtl/apu_envelope_length_unit_pkg.sv
// Shared APU constants: control-register bit positions and the 32-entry
// length-counter load table (also used by the triangle linear-counter block).
package apu_envelope_length_unit_pkg;

    localparam int CTRL_HALT  = 5;
    localparam int CTRL_CONST = 4;
    localparam int LEN_W      = 8;
    localparam int VOL_W      = 4;

    function automatic logic [LEN_W-1:0] length_lookup(input logic [4:0] idx);
        logic [LEN_W-1:0] len;
        case (idx)
            5'd0:  len = 8'd10;
            5'd1:  len = 8'd254;
            5'd2:  len = 8'd20;
            5'd3:  len = 8'd2;
            5'd4:  len = 8'd40;
            5'd5:  len = 8'd4;
            5'd6:  len = 8'd80;
            5'd7:  len = 8'd6;
            5'd8:  len = 8'd160;
            5'd9:  len = 8'd8;
            5'd10: len = 8'd60;
            5'd11: len = 8'd10;
            5'd12: len = 8'd14;
            5'd13: len = 8'd12;
            5'd14: len = 8'd26;
            5'd15: len = 8'd14;
            5'd16: len = 8'd12;
            5'd17: len = 8'd16;
            5'd18: len = 8'd24;
            5'd19: len = 8'd18;
            5'd20: len = 8'd48;
            5'd21: len = 8'd20;
            5'd22: len = 8'd96;
            5'd23: len = 8'd22;
            5'd24: len = 8'd192;
            5'd25: len = 8'd24;
            5'd26: len = 8'd72;
            5'd27: len = 8'd26;
            5'd28: len = 8'd16;
            5'd29: len = 8'd28;
            5'd30: len = 8'd32;
            default: len = 8'd30;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/apu_envelope_length_unit_length_counter.sv
// APU length counter: table load on register write, clear on disable,
// decrement on half-frame pulses unless halted, saturating at zero.
module apu_length_counter
    import apu_envelope_length_unit_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             l_pulse_in,
    input  logic             len_wr_in,
    input  logic [4:0]       len_idx_in,
    input  logic             en_in,
    input  logic             halt_in,
    output logic [LEN_W-1:0] len_out
);

    logic [LEN_W-1:0] q_len;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_len <= '0;
        end else if (!en_in) begin
            q_len <= '0;
        end else if (len_wr_in) begin
            // A load takes precedence over a coincident half-frame decrement.
            q_len <= length_lookup(len_idx_in);
        end else if (l_pulse_in && !halt_in && q_len != '0) begin
            q_len <= q_len - 1'b1;
        end
    end

    assign len_out = q_len;

endmodule

// File: rtl/apu_envelope_length_unit.sv
// Per-channel APU envelope generator and length counter, driven by the
// frame-sequencer quarter/half-frame pulses.
module apu_envelope_length_unit
    import apu_envelope_length_unit_pkg::*;
#(
    parameter bit ENV_PRESENT = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             e_pulse_in,
    input  logic             l_pulse_in,
    input  logic             ctrl_wr_in,
    input  logic [5:0]       ctrl_in,
    input  logic             len_wr_in,
    input  logic [4:0]       len_idx_in,
    input  logic             en_in,
    output logic [VOL_W-1:0] volume_out,
    output logic             active_out
);

    logic             q_halt;
    logic [LEN_W-1:0] len;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_halt <= 1'b0;
        end else if (ctrl_wr_in) begin
            q_halt <= ctrl_in[CTRL_HALT];
        end
    end

    apu_length_counter u_length_counter (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .l_pulse_in (l_pulse_in),
        .len_wr_in  (len_wr_in),
        .len_idx_in (len_idx_in),
        .en_in      (en_in),
        .halt_in    (q_halt),
        .len_out    (len)
    );

    assign active_out = (len != '0);

    generate
        if (ENV_PRESENT) begin : gen_env
            logic             q_const;
            logic [VOL_W-1:0] q_period;
            logic             q_start;
            logic [VOL_W-1:0] q_div;
            logic [VOL_W-1:0] q_decay;

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    q_const  <= 1'b0;
                    q_period <= '0;
                    q_start  <= 1'b0;
                    q_div    <= '0;
                    q_decay  <= '0;
                end else begin
                    if (ctrl_wr_in) begin
                        q_const  <= ctrl_in[CTRL_CONST];
                        q_period <= ctrl_in[3:0];
                    end

                    if (e_pulse_in) begin
                        if (q_start) begin
                            q_start <= 1'b0;
                            q_decay <= 4'hF;
                            q_div   <= q_period;
                        end else if (q_div == '0) begin
                            q_div <= q_period;
                            if (q_decay != '0) begin
                                q_decay <= q_decay - 1'b1;
                            end else if (q_halt) begin
                                q_decay <= 4'hF;
                            end
                        end else begin
                            q_div <= q_div - 1'b1;
                        end
                    end

                    // Placed last so a length write beats the clear above; the
                    // restart itself waits for the next quarter-frame.
                    if (len_wr_in) begin
                        q_start <= 1'b1;
                    end
                end
            end

            assign volume_out = q_const ? q_period : q_decay;
        end else begin : gen_no_env
            assign volume_out = '0;
        end
    endgenerate

endmodule

// File: tb/tb_apu_envelope_length_unit.sv
// Self-checking bench for apu_envelope_length_unit: a behavioural model pushes
// expected outputs to a scoreboard each cycle, plus directed literal checks.
module tb_apu_envelope_length_unit;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       e_pulse_in = 1'b0;
    logic       l_pulse_in = 1'b0;
    logic       ctrl_wr_in = 1'b0;
    logic [5:0] ctrl_in = '0;
    logic       len_wr_in = 1'b0;
    logic [4:0] len_idx_in = '0;
    logic       en_in = 1'b0;
    logic [3:0] volume_out;
    logic       active_out;

    always #5 clk_in = ~clk_in;

    apu_envelope_length_unit #(.ENV_PRESENT(1'b1)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .e_pulse_in (e_pulse_in),
        .l_pulse_in (l_pulse_in),
        .ctrl_wr_in (ctrl_wr_in),
        .ctrl_in    (ctrl_in),
        .len_wr_in  (len_wr_in),
        .len_idx_in (len_idx_in),
        .en_in      (en_in),
        .volume_out (volume_out),
        .active_out (active_out)
    );

    typedef struct packed {
        logic [3:0] vol;
        logic       act;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int len_tab[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Reference model state
    int m_len, m_div, m_decay, m_period;
    bit m_halt, m_const, m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        int  n_len, n_div, n_decay;
        bit  n_start;
        exp_t e;
        if (rst_in) begin
            m_len = 0; m_div = 0; m_decay = 0; m_period = 0;
            m_halt = 0; m_const = 0; m_start = 0;
        end else begin
            n_len = m_len;
            if (!en_in)                                  n_len = 0;
            else if (len_wr_in)                          n_len = len_tab[len_idx_in];
            else if (l_pulse_in && !m_halt && m_len > 0) n_len = m_len - 1;

            n_start = m_start; n_div = m_div; n_decay = m_decay;
            if (e_pulse_in) begin
                if (m_start) begin
                    n_start = 0; n_decay = 15; n_div = m_period;
                end else if (m_div == 0) begin
                    n_div = m_period;
                    if (m_decay > 0) n_decay = m_decay - 1;
                    else if (m_halt) n_decay = 15;
                end else begin
                    n_div = m_div - 1;
                end
            end
            if (len_wr_in) n_start = 1;

            if (ctrl_wr_in) begin
                m_halt = ctrl_in[5]; m_const = ctrl_in[4]; m_period = int'(ctrl_in[3:0]);
            end
            m_len = n_len; m_start = n_start; m_div = n_div; m_decay = n_decay;
        end
        e.vol = m_const ? 4'(m_period) : 4'(m_decay);
        e.act = (m_len != 0);
        sb.push_back(e);
    endtask

    // Drive one clock of stimulus, predict, then compare at edge + 1.
    task automatic cyc(input string tag, input logic e, input logic l, input logic cw,
                       input logic [5:0] c, input logic lw, input logic [4:0] idx);
        exp_t x;
        e_pulse_in = e; l_pulse_in = l; ctrl_wr_in = cw; ctrl_in = c;
        len_wr_in = lw; len_idx_in = idx;
        model_tick();
        @(posedge clk_in);
        #1;
        e_pulse_in = 0; l_pulse_in = 0; ctrl_wr_in = 0; len_wr_in = 0;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed vol %0d act %0d", tag, volume_out, active_out);
        end else begin
            x = sb.pop_front();
            check({tag, "_vol"}, volume_out, x.vol);
            check({tag, "_act"}, active_out, x.act);
        end
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 6'h00, 0, 5'd0);
    endtask
    task automatic epulse(input string tag);
        cyc(tag, 1, 0, 0, 6'h00, 0, 5'd0);
    endtask
    task automatic lpulse(input string tag);
        cyc(tag, 0, 1, 0, 6'h00, 0, 5'd0);
    endtask
    task automatic ctrl_wr(input string tag, input logic [5:0] c);
        cyc(tag, 0, 0, 1, c, 0, 5'd0);
    endtask
    task automatic len_wr(input string tag, input logic [4:0] idx);
        cyc(tag, 0, 0, 0, 6'h00, 1, idx);
    endtask

    initial begin
        int exp_vol;

        // Reset
        rst_in = 1;
        idle("reset");
        idle("reset");
        rst_in = 0;
        idle("post_reset");
        check("reset_vol", volume_out, 0);
        check("reset_act", active_out, 0);

        // Length 254 countdown, halt clear
        en_in = 1;
        len_wr("load254", 5'd1);
        check("load254_active", active_out, 1);
        for (int i = 1; i <= 253; i++) lpulse("cnt254");
        check("cnt254_253", active_out, 1);
        lpulse("cnt254_last");
        check("cnt254_zero", active_out, 0);
        lpulse("cnt254_extra");
        check("cnt254_nowrap", active_out, 0);

        // Halt holds the count; disable clears it and blocks loads
        ctrl_wr("halt_on", 6'b100000);
        len_wr("load2", 5'd3);
        for (int i = 0; i < 5; i++) lpulse("halted");
        check("halted_active", active_out, 1);
        en_in = 0;
        idle("disable");
        check("disable_clears", active_out, 0);
        len_wr("load_disabled", 5'd1);
        check("load_disabled", active_out, 0);
        en_in = 1;

        // Envelope, period 2, no loop
        ctrl_wr("env_p2_cfg", 6'b000010);
        len_wr("env_p2_start", 5'd0);
        for (int k = 1; k <= 50; k++) begin
            epulse("env_p2");
            exp_vol = ((k - 1) / 3 >= 15) ? 0 : 15 - (k - 1) / 3;
            check($sformatf("env_p2_k%0d", k), volume_out, exp_vol);
            idle("env_p2_gap");
        end

        // Envelope, period 0, loop
        ctrl_wr("env_loop_cfg", 6'b100000);
        len_wr("env_loop_start", 5'd0);
        for (int k = 1; k <= 17; k++) begin
            epulse("env_loop");
            exp_vol = (k <= 16) ? 16 - k : 15;
            check($sformatf("env_loop_k%0d", k), volume_out, exp_vol);
        end

        // Constant volume
        ctrl_wr("const9", 6'b010000 | 6'd9);
        check("const9_next_clk", volume_out, 9);
        for (int i = 0; i < 3; i++) begin
            epulse("const9_epulse");
            check("const9_hold", volume_out, 9);
        end
        ctrl_wr("const_off", 6'b000000);

        // Load coincident with l_pulse wins: 40 pulses to empty, not 39
        cyc("load40_lpulse", 0, 1, 0, 6'h00, 1, 5'd4);
        for (int i = 1; i <= 39; i++) lpulse("cnt40");
        check("cnt40_39", active_out, 1);
        lpulse("cnt40_last");
        check("cnt40_zero", active_out, 0);

        // len_wr coincident with e_pulse defers the restart
        epulse("restart_a");
        check("restart_a", volume_out, 15);
        epulse("restart_b");
        epulse("restart_c");
        check("restart_c", volume_out, 13);
        cyc("wr_with_e", 1, 0, 0, 6'h00, 1, 5'd2);
        check("wr_with_e_no_restart", volume_out, 12);
        epulse("restart_next");
        check("restart_next", volume_out, 15);

        // Simultaneous quarter and half frame
        cyc("both_pulses", 1, 1, 0, 6'h00, 0, 5'd0);
        check("both_pulses_vol", volume_out, 14);

        // Reset mid-count ignores coincident pulses
        len_wr("pre_rst_load", 5'd1);
        for (int i = 0; i < 3; i++) cyc("pre_rst", 1, 1, 0, 6'h00, 0, 5'd0);
        rst_in = 1;
        cyc("rst_mid", 1, 1, 0, 6'h00, 0, 5'd0);
        check("rst_mid_vol", volume_out, 0);
        check("rst_mid_act", active_out, 0);
        rst_in = 0;
        idle("post_rst_mid");
        check("post_rst_mid_act", active_out, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_in = ($urandom_range(99) < 2);
            en_in  = ($urandom_range(99) < 90);
            cyc("rand",
                logic'($urandom_range(99) < 30),
                logic'($urandom_range(99) < 30),
                logic'($urandom_range(99) < 8),
                6'($urandom),
                logic'($urandom_range(99) < 8),
                5'($urandom));
        end
        rst_in = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, observed %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apu_envelope_length_unit.md
Name: apu_envelope_length_unit

Overview:
- Per-channel consumer of the APU frame-sequencer pulses.
- Quarter-frame pulse (e_pulse) clocks a 4-bit envelope decay generator. Half-frame pulse (l_pulse) clocks an 8-bit length counter loaded from the standard 32-entry length table.
- Instantiated once per pulse/noise channel, and once in length-only form for the triangle channel.
- Outputs feed the channel mixer (volume) and the $4015 status read (active).

Parameters:
- ENV_PRESENT, 1, 1 = envelope logic built; 0 = envelope omitted and volume_out tied to 4'h0 (triangle use).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- e_pulse_in  input  1  quarter-frame pulse, 1 clk wide (~240 Hz)
- l_pulse_in  input  1  half-frame pulse, 1 clk wide (~120 Hz)
- ctrl_wr_in  input  1  write strobe for channel register 0 ($4000/$400C)
- ctrl_in  input  6  [5] loop/length-halt, [4] constant volume, [3:0] volume/envelope period
- len_wr_in  input  1  write strobe for length register ($4003/$400F)
- len_idx_in  input  5  length table index (data bits [7:3])
- en_in  input  1  channel enable from $4015, level
- volume_out  output  4  envelope or constant volume
- active_out  output  1  length counter != 0

Behaviour:
- Registers: q_halt, q_const, q_period[3:0] (loaded on ctrl_wr_in, visible next cycle); q_start; q_div[3:0]; q_decay[3:0]; q_len[7:0].
- Reset: all registers 0. volume_out = 0, active_out = 0.
- Length table, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Length counter priority, per cycle:
  - 1) !en_in -> q_len := 0. Loads are ignored while disabled.
  - 2) len_wr_in && en_in -> q_len := table[len_idx_in]. A load wins over a simultaneous l_pulse_in.
  - 3) l_pulse_in && !q_halt && q_len != 0 -> q_len := q_len - 1.
  - q_len never wraps below 0.
- Halt uses the registered value. A ctrl_wr_in in the same cycle as l_pulse_in affects only later pulses.
- active_out = (q_len != 0). It is combinational from the register, with no extra latency.
- Start flag:
  - len_wr_in sets q_start := 1, regardless of en_in. This set overrides a clear in the same cycle.
  - The e_pulse in that same cycle acts on the old q_start. The restart is deferred to the next e_pulse.
- Envelope on e_pulse_in (ENV_PRESENT = 1):
  - q_start = 1 -> q_start := 0 (unless set again this cycle), q_decay := 15, q_div := q_period.
  - Else if q_div = 0 -> q_div := q_period. Then:
    - if q_decay != 0, q_decay := q_decay - 1;
    - else if q_halt (loop), q_decay := 15;
    - else hold at 0.
  - Else q_div := q_div - 1.
  - Divider period is q_period + 1 quarter-frames. q_period = 0 decrements decay on every e_pulse.
- volume_out = q_const ? q_period : q_decay. It is combinational from registers, so a ctrl write takes effect 1 clk later.
- volume_out does not depend on active_out. The mixer gates silence.
- Simultaneous e_pulse_in and l_pulse_in (frame sequencer half-frame steps): both sections update independently in the same cycle.
- Reset asserted mid-count clears all state on the next edge. Pulses arriving during reset are ignored.
- ENV_PRESENT = 0: q_start, q_div, q_decay and q_const are not built. Length logic is unchanged.

Decomposition:
- Shared apu package holds:
  - the 32×8 length table as a constant function/array (also reused by the triangle linear-counter block);
  - ctrl bit-position constants (CTRL_HALT = 5, CTRL_CONST = 4).
- One natural sub-module: apu_length_counter (table lookup, enable, halt, decrement), instantiated here.
- Envelope stays inline, under a generate on ENV_PRESENT.

Test Plan:
- Reset, then en_in = 1, len_wr idx = 1 -> active_out = 1, q_len = 254. Then 254 l_pulses with halt = 0 -> active_out drops to 0 exactly on the 254th; a further pulse keeps it 0.
- en_in = 1, load idx = 3 (len 2), ctrl halt = 1, 5 l_pulses -> active_out stays 1. Then en_in = 0 -> active_out = 0 next clk, and a len_wr while disabled leaves it 0.
- ctrl = {halt 0, const 0, period 2}, len_wr, then e_pulses:
  - 1st e_pulse -> volume 15;
  - volume reaches 14 on the 4th e_pulse, then steps every 3 e_pulses;
  - holds at 0 after reaching 0.
- Same setup with loop = 1, period 0 -> volume 15, 14, …, 0, 15 on consecutive e_pulses (wrap on the 17th).
- ctrl const = 1, vol = 9 -> volume_out = 9 one clk after the write, unaffected by e_pulses. Switching to const = 0 shows the current decay value.
- Load idx = 4 (40) in the same cycle as l_pulse -> q_len = 40, not 39. len_wr coincident with e_pulse -> no restart on that pulse; restart to 15 on the next e_pulse.
